// File: rtl/ysyx_25010008_ifu_prefetch.sv
// Pipelined instruction fetch: up to DEPTH outstanding AXI4-Lite reads feeding a DEPTH-entry FIFO.
// Optional performance counters are enabled with `define IFU_PERF_EN.
module ysyx_25010008_ifu_prefetch #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h3000_0000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] araddr,
    output logic            arvalid,
    input  logic            arready,
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      rresp,
    input  logic            rvalid,
    output logic            rready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_fault,
    output logic            inst_valid,
`ifdef IFU_PERF_EN
    output logic [31:0]     perf_fetch,
    output logic [31:0]     perf_drop,
    output logic [31:0]     perf_stall,
`endif
    input  logic            inst_ready
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = CW + 1;

    logic [XLEN-1:0] mem_data [DEPTH];
    logic [XLEN-1:0] mem_pc   [DEPTH];
    logic [XLEN-1:0] pc_q     [DEPTH];
    logic [DEPTH-1:0] mem_fault;
    logic [PW-1:0]   wr_ptr, rd_ptr, pq_wr, pq_rd;
    logic [CW-1:0]   count, outstanding, drop;
    logic            halted, stale;
    logic [XLEN-1:0] fetch_pc;

    logic            ar_fire, r_fire, pop, discard, push, hold;
    logic [CW-1:0]   count_nx, out_nx, drop_nx;
    logic            halted_nx, stale_nx, arvalid_nx;
    logic [XLEN-1:0] fetch_pc_nx, araddr_nx;

    assign inst       = mem_data[rd_ptr];
    assign inst_pc    = mem_pc[rd_ptr];
    assign inst_fault = mem_fault[rd_ptr];
    assign inst_valid = (count != '0);

    // Next-state: space is reserved per request so responses are never back-pressured.
    always_comb begin
        ar_fire     = arvalid & arready;
        r_fire      = rvalid & rready;
        pop         = inst_valid & inst_ready;
        hold        = arvalid & ~arready;
        discard     = r_fire & (redirect_valid | (drop != '0));
        push        = r_fire & ~discard;
        out_nx      = outstanding + CW'(ar_fire) - CW'(r_fire);
        count_nx    = count + CW'(push) - CW'(pop);
        halted_nx   = halted | (push & (rresp != 2'b00));
        drop_nx     = drop - CW'(r_fire & (drop != '0)) + CW'(ar_fire & stale);
        stale_nx    = ar_fire ? 1'b0 : stale;
        fetch_pc_nx = (ar_fire & ~stale) ? fetch_pc + XLEN'(4) : fetch_pc;
        if (redirect_valid) begin
            count_nx    = '0;
            halted_nx   = 1'b0;
            drop_nx     = out_nx;
            stale_nx    = hold;
            fetch_pc_nx = redirect_pc & ~XLEN'(3);
        end
        arvalid_nx = arvalid;
        araddr_nx  = araddr;
        if (!hold) begin
            arvalid_nx = ~halted_nx &
                         (({1'b0, count_nx} + {1'b0, out_nx}) < SW'(DEPTH));
            araddr_nx  = fetch_pc_nx;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            arvalid     <= 1'b0;
            araddr      <= RESET_PC;
            rready      <= 1'b0;
            fetch_pc    <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            halted      <= 1'b0;
            stale       <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            pq_wr       <= '0;
            pq_rd       <= '0;
            mem_fault   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_data[i] <= '0;
                mem_pc[i]   <= '0;
                pc_q[i]     <= '0;
            end
        end else begin
            arvalid     <= arvalid_nx;
            araddr      <= araddr_nx;
            rready      <= 1'b1;
            fetch_pc    <= fetch_pc_nx;
            count       <= count_nx;
            outstanding <= out_nx;
            drop        <= drop_nx;
            halted      <= halted_nx;
            stale       <= stale_nx;
            if (ar_fire) begin
                pc_q[pq_wr] <= araddr;
                pq_wr       <= pq_wr + PW'(1);
            end
            if (r_fire) begin
                pq_rd <= pq_rd + PW'(1);
            end
            if (push) begin
                mem_data[wr_ptr]  <= rdata;
                mem_pc[wr_ptr]    <= pc_q[pq_rd];
                mem_fault[wr_ptr] <= (rresp != 2'b00);
                wr_ptr            <= wr_ptr + PW'(1);
            end
            // A redirect never pushes, so wr_ptr is the post-flush head.
            if (redirect_valid) begin
                rd_ptr <= wr_ptr;
            end else if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

`ifdef IFU_PERF_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_fetch <= '0;
            perf_drop  <= '0;
            perf_stall <= '0;
        end else begin
            perf_fetch <= perf_fetch + 32'(push);
            perf_drop  <= perf_drop + 32'(discard);
            perf_stall <= perf_stall + 32'(~inst_valid & inst_ready);
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_25010008_ifu_prefetch.sv
// Randomized bench for ysyx_25010008_ifu_prefetch with an epoch-tagged AXI slave and stream model.
module tb_ysyx_25010008_ifu_prefetch;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h3000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
`ifdef IFU_PERF_EN
    logic [31:0] perf_fetch, perf_drop, perf_stall;
`endif

    ysyx_25010008_ifu_prefetch #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clock(clock), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .inst(inst), .inst_pc(inst_pc), .inst_fault(inst_fault),
        .inst_valid(inst_valid),
`ifdef IFU_PERF_EN
        .perf_fetch(perf_fetch), .perf_drop(perf_drop), .perf_stall(perf_stall),
`endif
        .inst_ready(inst_ready)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        int          tag;
    } ar_t;

    ar_t         slave_q[$];
    int          n_tests = 0, n_fail = 0;
    int          p_ar, p_r, p_ir, p_rd;
    logic        force_rd = 1'b0;
    logic        fault_on = 1'b0;
    logic [5:0]  fault_idx = '0;
    logic [31:0] exp_pc, ar_exp, prev_addr;
    int          epoch, ar_count, pops = 0;
    logic        stale_pend, halted_seen, halt_allow, prev_hold, lat_pend;
    int          exp_fetch, exp_drop, exp_stall;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic is_bad(input logic [31:0] a);
        return fault_on && (a[7:2] == fault_idx);
    endfunction

    task automatic model_init();
        slave_q.delete();
        exp_pc = RESET_PC; ar_exp = RESET_PC; epoch = 0; ar_count = 0;
        stale_pend = 0; halted_seen = 0; halt_allow = 0; prev_hold = 0; lat_pend = 0;
        exp_fetch = 0; exp_drop = 0; exp_stall = 0; prev_addr = '0;
    endtask

    // Entered at a negedge; optional delay lands the reset mid-cycle.
    task automatic do_reset(input int pre_delay);
        #(pre_delay);
        reset = 1'b0; arready = 1'b0; rvalid = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
        #1;
        check("rst_arvalid", 32'(arvalid), 32'd0);
        check("rst_araddr", araddr, RESET_PC);
        check("rst_rready", 32'(rready), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_inst_fault", 32'(inst_fault), 32'd0);
`ifdef IFU_PERF_EN
        check("rst_perf", perf_fetch | perf_drop | perf_stall, 32'd0);
`endif
        repeat (2) @(negedge clock);
        model_init();
        reset = 1'b1;
        @(negedge clock);
        check("rel_arvalid", 32'(arvalid), 32'd1);
        check("rel_araddr", araddr, RESET_PC);
        check("rel_rready", 32'(rready), 32'd1);
    endtask

    // One clock: drive at negedge, check, update model for the coming posedge.
    task automatic step();
        logic arf, rf, pp, disc;
        logic [31:0] rpc;
        ar_t e;
        arready    = ($urandom_range(99) < p_ar);
        inst_ready = ($urandom_range(99) < p_ir);
        case ($urandom_range(3))
            0:       rpc = 32'h8000_0000;
            1:       rpc = 32'hFFFF_FFF8 | 32'($urandom_range(3));
            default: rpc = $urandom;
        endcase
        redirect_valid = ($urandom_range(999) < p_rd);
        if (force_rd) begin
            redirect_valid = 1'b1;
            rpc = 32'h8000_0000;
        end
        redirect_pc = rpc;
        if (slave_q.size() > 0 && $urandom_range(99) < p_r) begin
            rvalid = 1'b1;
            rdata  = mem_word(slave_q[0].addr);
            rresp  = is_bad(slave_q[0].addr) ? 2'd2 : 2'd0;
        end else begin
            rvalid = 1'b0;
            rdata  = $urandom;
            rresp  = 2'($urandom_range(3));
        end
        #1;
        check("rready", 32'(rready), 32'd1);
        check("outst_bound", 32'(slave_q.size() <= DEPTH), 32'd1);
        if (prev_hold) begin
            check("ar_hold_valid", 32'(arvalid), 32'd1);
            check("ar_hold_addr", araddr, prev_addr);
        end
        if (lat_pend) check("latency", 32'(inst_valid), 32'd1);
        if (halted_seen) begin
            check("halt_no_ar", 32'(arvalid && !halt_allow), 32'd0);
            if (!arvalid || arready) halt_allow = 1'b0;
        end
        arf = arvalid && arready;
        rf  = rvalid && rready;
        pp  = inst_valid && inst_ready;
        if (!inst_valid && inst_ready) exp_stall++;
        if (pp) begin
            check("inst_pc", inst_pc, exp_pc);
            check("inst", inst, mem_word(exp_pc));
            check("inst_fault", 32'(inst_fault), 32'(is_bad(exp_pc)));
            if (is_bad(exp_pc)) begin
                halted_seen = 1'b1;
                halt_allow  = arvalid && !arready;
            end
            exp_pc += 32'd4;
            pops++;
        end
        if (arf) begin
            e.addr = araddr;
            if (stale_pend) begin
                e.tag = -1;
                stale_pend = 1'b0;
            end else begin
                check("araddr", araddr, ar_exp);
                e.tag = epoch;
                ar_exp += 32'd4;
            end
            slave_q.push_back(e);
            ar_count++;
        end
        lat_pend = 1'b0;
        if (rf) begin
            e = slave_q.pop_front();
            disc = redirect_valid || (e.tag != epoch);
            if (disc) exp_drop++;
            else begin
                exp_fetch++;
                if (!inst_valid) lat_pend = 1'b1;
            end
        end
        if (redirect_valid) begin
            epoch++;
            exp_pc      = rpc & ~32'd3;
            ar_exp      = exp_pc;
            stale_pend  = arvalid && !arready;
            halted_seen = 1'b0;
        end
        prev_hold = arvalid && !arready;
        prev_addr = araddr;
        @(negedge clock);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        p_ar = 100; p_r = 100; p_ir = 100; p_rd = 0;
        model_init();
        @(negedge clock);
        do_reset(0);

        // Streaming: one instruction per cycle once filled.
        for (int i = 0; i < 30; i++) begin
            if (i >= 4) check("stream_full", 32'(inst_valid), 32'd1);
            step();
        end

        // IDU stalled: exactly DEPTH reads, then resume after the first pop.
        do_reset(0);
        p_ir = 0;
        repeat (12) step();
        check("t2_ar_count", 32'(ar_count), 32'(DEPTH));
        check("t2_arvalid", 32'(arvalid), 32'd0);
        check("t2_inst_valid", 32'(inst_valid), 32'd1);
        p_ir = 100;
        step();
        check("t2_resume", 32'(arvalid), 32'd1);

        // Error response on 0x30000004 halts fetch until a redirect.
        do_reset(0);
        fault_on = 1'b1; fault_idx = 6'd1;
        repeat (20) step();
        check("t5_halted", 32'(halted_seen), 32'd1);
        check("t5_no_ar", 32'(arvalid), 32'd0);
        force_rd = 1'b1; step(); force_rd = 1'b0;
        base = pops;
        repeat (20) step();
        check("t5_resumed", 32'(pops > base), 32'd1);

        // Redirect with reads outstanding.
        do_reset(0);
        fault_on = 1'b0;
        p_r = 0;
        repeat (3) step();
        force_rd = 1'b1; step(); force_rd = 1'b0;
        p_r = 100;
        base = pops;
        repeat (20) step();
        check("t3_resumed", 32'(pops > base), 32'd1);

        // Redirect while an AR is stalled at 0x30000008.
        do_reset(0);
        repeat (2) step();
        p_ar = 0;
        check("t4_pending", araddr, 32'h3000_0008);
        force_rd = 1'b1; step(); force_rd = 1'b0;
        repeat (3) step();
        p_ar = 100;
        repeat (20) step();

        // Randomized traffic with a mid-burst reset.
        fault_on = 1'b1; fault_idx = 6'h15;
        p_ar = 60; p_r = 60; p_ir = 70; p_rd = 20;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset(2);
            step();
        end
        p_ar = 85; p_r = 40; p_ir = 50; p_rd = 80;
        repeat (2000) step();
        p_rd = 0;
        repeat (50) step();

        check("liveness", 32'(pops > 200), 32'd1);
`ifdef IFU_PERF_EN
        check("perf_fetch", perf_fetch, 32'(exp_fetch));
        check("perf_drop", perf_drop, 32'(exp_drop));
        check("perf_stall", perf_stall, 32'(exp_stall));
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
